// File: rtl/md_defs.sv
// rtl/md_defs.sv - shared op and state encodings for the multiply/divide unit
package md_defs;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // True for the ops that occupy the unit for a multi-cycle latency
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational product and quotient/remainder for the md unit
module md_calc
    import md_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] uq;
    logic [31:0] ur;

    // Signed division is done on magnitudes, then the signs are restored:
    // quotient truncates toward zero and the remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    always_comb begin
        prod_s     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u     = {32'd0, a} * {32'd0, b};
        signed_div = (op == MD_DIV);
        neg_r      = signed_div & a[31];
        neg_q      = signed_div & (a[31] ^ b[31]);
        mag_a      = neg_r ? (~a + 32'd1) : a;
        mag_b      = (signed_div & b[31]) ? (~b + 32'd1) : b;
        div_zero   = (b == 32'd0);
        // Keep the divider well defined; the result is discarded on b == 0
        divisor    = div_zero ? 32'd1 : mag_b;
        uq         = mag_a / divisor;
        ur         = mag_a % divisor;
        res_hi     = 32'd0;
        res_lo     = 32'd0;
        case (op)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV, MD_DIVU: begin
                res_hi = neg_r ? (~ur + 32'd1) : ur;
                res_lo = neg_q ? (~uq + 32'd1) : uq;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multiply/divide responder with fixed latency and HI/LO registers
module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        irq,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_e   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_we_q, pend_we_d;

    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_div_zero;
    logic        req_ok;

    md_calc u_calc (
        .op       (op),
        .a        (a),
        .b        (b),
        .res_hi   (calc_hi),
        .res_lo   (calc_lo),
        .div_zero (calc_div_zero)
    );

    // Next-state: accept requests in IDLE, count down in RUN, commit on the last busy cycle
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        req_ok    = start & ~irq & ~busy_q;
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    if (md_is_arith(op)) begin
                        state_d   = RUN;
                        busy_d    = 1'b1;
                        count_d   = md_is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        pend_hi_d = calc_hi;
                        pend_lo_d = calc_lo;
                        // A divide by zero still burns its cycles but leaves HI/LO alone
                        pend_we_d = ~(md_is_div(op) & calc_div_zero);
                    end else if (op == MD_MTHI) begin
                        hi_d = a;
                    end else if (op == MD_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            RUN: begin
                // Already committed: irq no longer affects an in-flight operation
                if (count_q == CW'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    count_d = '0;
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    // State, counter, pending results and architectural HI/LO
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            count_q   <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit against a behavioural HI/LO model
module tb_md_unit;
    import md_defs::*;

    logic        clk;
    logic        clr;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        irq;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .irq   (irq),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
        int          blen;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          free_cyc = 0;
    int          run = 0;
    int          last_run = 0;
    int          viol = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: busy-run bookkeeping, protocol watch, and scoreboard pops at due cycles
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) run++;
        else begin
            if (run > 0) last_run = run;
            run = 0;
        end
        if (start === 1'b1 && busy === 1'b1) viol++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("hi", hi, e.hi);
            chk("lo", lo, e.lo);
            chk("busy_idle", {31'd0, busy}, 32'd0);
            if (e.blen >= 0) chk("busy_len", 32'(last_run), 32'(e.blen));
        end
    end

    // Reference: architectural effect of one accepted operation
    task automatic ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, sp, sq, sr;
        longint unsigned ux, uy, up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        case (o)
            MD_MULT: begin
                sp = sx * sy;
                {m_hi, m_lo} = sp;
            end
            MD_MULTU: begin
                up = ux * uy;
                {m_hi, m_lo} = up;
            end
            MD_DIV: if (y != 32'd0) begin
                sq = sx / sy;
                sr = sx % sy;
                m_lo = 32'(sq);
                m_hi = 32'(sr);
            end
            MD_DIVU: if (y != 32'd0) begin
                m_lo = 32'(ux / uy);
                m_hi = 32'(ux % uy);
            end
            MD_MTHI: m_hi = x;
            MD_MTLO: m_lo = x;
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic q);
        exp_t e;
        int   k;
        int   lat;
        k = cyc;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        irq = q;
        e.blen = -1;
        e.due = k + 1;
        free_cyc = k + 1;
        if (!q && o != MD_NONE) begin
            ref_op(o, x, y);
            if (o == MD_MULT || o == MD_MULTU || o == MD_DIV || o == MD_DIVU) begin
                lat = (o == MD_DIV || o == MD_DIVU) ? 10 : 5;
                e.due = k + 1 + lat;
                e.blen = lat;
                free_cyc = k + 1 + lat;
            end
        end
        e.hi = m_hi;
        e.lo = m_lo;
        exp_q.push_back(e);
        step();
        start = 1'b0;
        op = MD_NONE;
        irq = 1'b0;
    endtask

    task automatic wait_free();
        while (cyc < free_cyc) step();
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic        rq;
        clr = 1'b1;
        start = 1'b0;
        op = MD_NONE;
        a = 32'd0;
        b = 32'd0;
        irq = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        step();
        clr = 1'b0;
        step();

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_free();
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_free();
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_free();
        issue(MD_DIVU, 32'd7, 32'd0, 1'b0);
        wait_free();

        issue(MD_MULT, 32'd9, 32'd9, 1'b1);
        wait_free();
        issue(MD_DIV, 32'd100, 32'd7, 1'b0);
        repeat (3) step();
        irq = 1'b1;
        step();
        irq = 1'b0;
        wait_free();

        issue(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        wait_free();
        issue(MD_DIVU, 32'd1000, 32'd33, 1'b0);
        repeat (2) step();
        start = 1'b1;
        op = MD_MTLO;
        a = 32'hDEAD_BEEF;
        step();
        start = 1'b0;
        op = MD_NONE;
        wait_free();
        chk("start_while_busy_seen", 32'(viol), 32'd1);

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_free();
        issue(MD_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
        wait_free();

        issue(MD_DIV, 32'd50, 32'd3, 1'b0);
        repeat (3) step();
        clr = 1'b1;
        exp_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        free_cyc = cyc;
        #1;
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_hi", hi, 32'd0);
        chk("clr_lo", lo, 32'd0);
        step();
        clr = 1'b0;
        step();
        issue(MD_MULT, 32'd1234, 32'd5678, 1'b0);
        wait_free();

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            rq = ($urandom_range(0, 4) == 0);
            issue(ro, ra, rb, rq);
            wait_free();
            repeat ($urandom_range(0, 2)) step();
        end

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("no_extra_protocol_events", 32'(viol), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
